// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART drain path: state encoding and default line settings.
package fifo_uart_tx_pkg;

    localparam int DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int DEF_BAUD        = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LATCH = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: owns the baud counter, bit counter and START/DATA/STOP sequencing.
module uart_tx_byte
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_last,
    output state_t     o_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    state_t          r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_data;
    logic            r_tx;
    logic            w_bit_end;

    assign w_bit_end = (r_baud_cnt == CNT_LAST);
    // i_start is honoured in IDLE and on the last stop cycle, so bytes chain with no gap.
    assign o_last    = (r_state == ST_STOP) && w_bit_end;
    assign o_tx      = r_tx;
    assign o_state   = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
        end else begin
            if (r_state != ST_IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_START;
                        r_data  <= i_byte;
                        r_tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_data[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_data    <= {1'b0, r_data[7:1]};
                            r_tx      <= r_data[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (i_start) begin
                            r_state <= ST_START;
                            r_data  <= i_byte;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops 32-bit words from the FIFO and sends each as NBYTES UART bytes, least-significant first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BAUD        = DEF_BAUD,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       words_sent,
    output state_t            dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int NBYTES       = DATA_W / 8;
    localparam int IW           = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    // ST_START here means "word in flight"; the byte engine supplies START/DATA/STOP detail.
    state_t            r_state;
    logic              r_rd_en;
    logic              r_busy;
    logic [15:0]       r_words_sent;
    logic [DATA_W-1:0] r_shift;
    logic [IW-1:0]     r_byte_idx;

    logic [DATA_W-1:0] w_shift_nx;
    logic              w_byte_last;
    logic              w_more_bytes;
    logic              w_start;
    logic [7:0]        w_byte;
    state_t            w_tx_state;

    assign w_shift_nx   = r_shift >> 8;
    assign w_more_bytes = (r_byte_idx != IDX_LAST);
    assign w_start      = (r_state == ST_LATCH) ||
                          ((r_state == ST_START) && w_byte_last && w_more_bytes);
    assign w_byte       = (r_state == ST_LATCH) ? fifo_rd_data[7:0] : w_shift_nx[7:0];

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_byte  (w_byte),
        .o_tx    (tx),
        .o_last  (w_byte_last),
        .o_state (w_tx_state)
    );

    assign fifo_rd_en = r_rd_en;
    assign busy       = r_busy;
    assign words_sent = r_words_sent;
    assign dbg_state  = (r_state == ST_START) ? w_tx_state : r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_words_sent <= '0;
            r_shift      <= '0;
            r_byte_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_state <= ST_READ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state <= ST_LATCH;
                    r_rd_en <= 1'b0;
                end
                ST_LATCH: begin
                    r_state    <= ST_START;
                    r_shift    <= fifo_rd_data;
                    r_byte_idx <= '0;
                end
                ST_START: begin
                    if (w_byte_last) begin
                        if (w_more_bytes) begin
                            r_shift    <= w_shift_nx;
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_words_sent <= r_words_sent + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-backed FIFO model, UART line decoder and word-timing scoreboard.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BAUD_R   = 100_000;
    localparam int CPB      = CLK_HZ / BAUD_R;
    localparam int WORD_CYC = 4 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;
    state_t      dbg_state;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .DATA_W      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .tx           (tx),
        .busy         (busy),
        .words_sent   (words_sent),
        .dbg_state    (dbg_state)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int         cyc = 0;
    int         n_pop = 0;
    int         exp_words = 0;
    int         start_cyc = 0;
    bit         in_word = 0;
    int         tx_low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && busy === 1'b0 && fifo_rd_en === 1'b0) done = 1;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    // FIFO model: a pop strobe seen in a cycle presents the head word before the next edge.
    initial begin
        fifo_rd_data = '0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1 && !rst) begin
                if (fifo_q.size() == 0) check("pop_when_empty", 1, 0);
                else fifo_rd_data = fifo_q.pop_front();
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    // Line monitor: pop strobes, word framing timing and an 8N1 decoder sampling mid-bit.
    initial begin
        bit prev_rd = 0, prev_busy = 0, await_start = 0, have_fall = 0, q_at_fall = 0;
        bit rx_act = 0;
        int rd_cyc = 0, rd_w = 0, busy_fall_cyc = 0, rx_cnt = 0, k = 0;
        logic [7:0] rx_sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_rd = 0; prev_busy = 0; await_start = 0; have_fall = 0;
                in_word = 0; rx_act = 0;
                continue;
            end
            if (tx === 1'b0) tx_low_cnt++;
            if (fifo_rd_en && !prev_rd) begin
                n_pop++;
                rd_cyc = cyc;
                rd_w = 0;
                check("busy_with_read", busy, 1);
                if (have_fall && q_at_fall) check("idle_gap", cyc - busy_fall_cyc, 1);
                await_start = 1;
            end
            if (fifo_rd_en) rd_w++;
            if (!fifo_rd_en && prev_rd) check("rd_en_width", rd_w, 1);
            if (await_start && tx === 1'b0) begin
                check("start_latency", cyc - rd_cyc, 2);
                if (have_fall && q_at_fall) check("word_gap", cyc - busy_fall_cyc, 3);
                start_cyc = cyc;
                await_start = 0;
                in_word = 1;
            end
            if (prev_busy && !busy) begin
                if (in_word) check("word_len", cyc - start_cyc, WORD_CYC);
                in_word = 0;
                busy_fall_cyc = cyc;
                have_fall = 1;
                q_at_fall = (fifo_q.size() != 0);
            end
            if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= CPB/2 && (rx_cnt - CPB/2) % CPB == 0) begin
                    k = (rx_cnt - CPB/2) / CPB;
                    if (k == 0) check("rx_start", tx, 0);
                    else if (k <= 8) rx_sh[k-1] = tx;
                    else begin
                        check("rx_stop", tx, 1);
                        if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
                        else check("rx_byte", rx_sh, exp_q.pop_front());
                        rx_act = 0;
                    end
                end
            end
            prev_rd = fifo_rd_en;
            prev_busy = busy;
        end
    end

    initial begin
        int n_pop0, low0, nw;
        logic [31:0] w1;
        bit found;
        rst = 1'b1;
        fifo_empty = 1'b1;
        push_word(32'hA55A1234);

        repeat (4) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_rd_en", fifo_rd_en, 0);
            check("rst_busy", busy, 0);
            check("rst_words", words_sent, 0);
            check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        end
        @(posedge clk); #2 rst = 1'b0;

        wait_drain("single");
        exp_words = 1;
        check("single_words", words_sent, 32'(exp_words));
        check("single_busy", busy, 0);
        check("single_pops", n_pop, 1);
        check("single_bytes_left", exp_q.size(), 0);

        n_pop0 = n_pop;
        low0 = tx_low_cnt;
        repeat (1000) @(negedge clk);
        check("empty_pops", n_pop - n_pop0, 0);
        check("empty_tx_low", tx_low_cnt - low0, 0);

        @(posedge clk); #2;
        push_word(32'h0000_0001);
        push_word(32'hFFFF_FFFF);
        push_word(32'h8000_0000);
        wait_drain("b2b");
        exp_words += 3;
        check("b2b_pops", n_pop - n_pop0, 3);
        check("b2b_words", words_sent, 32'(exp_words));

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #2;
            nw = 1 + $urandom_range(0, 1);
            for (int j = 0; j < nw; j++) push_word($urandom);
            wait_drain("rand");
            exp_words += nw;
            check("rand_words", words_sent, 32'(exp_words));
        end

        // Abort inside byte 1, data bit 3 (forced to 0 so the line is visibly low).
        w1 = $urandom & ~32'h0000_0800;
        @(posedge clk); #2;
        push_word(w1);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (in_word && cyc == start_cyc + 10*CPB + CPB + 3*CPB + CPB/2) found = 1;
        end
        if (!found) check("midrst_timeout", 0, 1);
        check("pre_rst_tx", tx, 0);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_words", words_sent, 0);
        exp_words = 0;
        push_word($urandom);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        wait_drain("post_rst");
        exp_words = 1;
        check("post_rst_words", words_sent, 32'(exp_words));
        check("post_rst_bytes_left", exp_q.size(), 0);

        @(negedge clk);
        force dut.r_words_sent = 16'hFFFF;
        @(negedge clk);
        release dut.r_words_sent;
        @(negedge clk);
        check("wrap_preload", words_sent, 32'hFFFF);
        @(posedge clk); #2;
        push_word($urandom);
        wait_drain("wrap");
        check("wrap_words", words_sent, 0);

        check("bytes_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
